// File: rtl/interval_capture.sv
// Measures clk cycles between a start rising edge and a stop rising edge.
// The captured result is held until the consumer acknowledges it.
module interval_capture #(
   parameter int ISIZE = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             ack,
   output logic [ISIZE-1:0] elapsed,
   output logic             overflow,
   output logic             valid,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [ISIZE-1:0] ONE = {{(ISIZE-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [ISIZE-1:0] r_cnt;
   logic             r_sat;
   logic [ISIZE-1:0] r_elapsed;
   logic             r_overflow;
   logic             r_start_q;
   logic             r_stop_q;

   logic w_start_edge;
   logic w_stop_edge;
   logic w_cnt_max;

   assign w_start_edge = start & ~r_start_q;
   assign w_stop_edge  = stop & ~r_stop_q;
   assign w_cnt_max    = &r_cnt;

   // Edge history resets high so a level already asserted is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_sat      <= 1'b0;
         r_elapsed  <= '0;
         r_overflow <= 1'b0;
         r_start_q  <= 1'b1;
         r_stop_q   <= 1'b1;
      end else begin
         r_start_q <= start;
         r_stop_q  <= stop;
         case (r_state)
            S_IDLE: begin
               if (w_start_edge) begin
                  r_state <= S_COUNT;
                  r_cnt   <= ONE;
                  r_sat   <= 1'b0;
               end
            end
            S_COUNT: begin
               if (w_start_edge) begin
                  r_cnt <= ONE;
                  r_sat <= 1'b0;
               end else if (w_stop_edge) begin
                  r_state    <= S_DONE;
                  r_elapsed  <= r_cnt;
                  r_overflow <= r_sat;
               end else if (!w_cnt_max) begin
                  r_cnt <= r_cnt + ONE;
               end else begin
                  r_sat <= 1'b1;
               end
            end
            S_DONE: begin
               if (ack) begin
                  if (w_start_edge) begin
                     r_state <= S_COUNT;
                     r_cnt   <= ONE;
                     r_sat   <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign elapsed  = r_elapsed;
   assign overflow = r_overflow;
   assign valid    = (r_state == S_DONE);
   assign busy     = (r_state == S_COUNT);

endmodule

// File: tb/tb_interval_capture.sv
// Bench for interval_capture: 16-bit and 4-bit instances checked
// against a timestamp-based reference model.
module tb_interval_capture;

   logic clk = 1'b0;
   logic reset;
   logic s16 = 1'b0, p16 = 1'b0, a16 = 1'b0;
   logic s4 = 1'b0, p4 = 1'b0, a4 = 1'b0;
   logic [15:0] el16;
   logic [3:0]  el4;
   logic ov16, v16, b16, ov4, v4, b4;

   int tests = 0;
   int fails = 0;
   longint cyc = 0;

   // model: mode 0 idle, 1 measuring, 2 holding a result
   int     mode[2];
   longint t0[2];
   longint mel[2];
   logic   mov[2];
   logic   ps[2], pp[2];
   longint maxv[2];

   always #5 clk = ~clk;

   interval_capture #(.ISIZE(16)) u16 (
      .clk(clk), .reset(reset), .start(s16), .stop(p16), .ack(a16),
      .elapsed(el16), .overflow(ov16), .valid(v16), .busy(b16)
   );

   interval_capture #(.ISIZE(4)) u4 (
      .clk(clk), .reset(reset), .start(s4), .stop(p4), .ack(a4),
      .elapsed(el4), .overflow(ov4), .valid(v4), .busy(b4)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mode[k] = 0;
         t0[k]   = 0;
         mel[k]  = 0;
         mov[k]  = 1'b0;
         ps[k]   = 1'b1;
         pp[k]   = 1'b1;
      end
   endtask

   task automatic model_step(input int k, input logic s, input logic p,
                             input logic a);
      logic se, pe;
      longint n;
      se = s & ~ps[k];
      pe = p & ~pp[k];
      ps[k] = s;
      pp[k] = p;
      case (mode[k])
         0: if (se) begin mode[k] = 1; t0[k] = cyc; end
         1: begin
            if (se) t0[k] = cyc;
            else if (pe) begin
               n = cyc - t0[k];
               mel[k] = (n > maxv[k]) ? maxv[k] : n;
               mov[k] = (n > maxv[k]);
               mode[k] = 2;
            end
         end
         default: begin
            if (a) begin
               if (se) begin mode[k] = 1; t0[k] = cyc; end
               else mode[k] = 0;
            end
         end
      endcase
   endtask

   task automatic check_all();
      chk("el16", 32'(el16), 32'(mel[0]));
      chk("ov16", 32'(ov16), 32'(mov[0]));
      chk("v16", 32'(v16), 32'(mode[0] == 2));
      chk("b16", 32'(b16), 32'(mode[0] == 1));
      chk("el4", 32'(el4), 32'(mel[1]));
      chk("ov4", 32'(ov4), 32'(mov[1]));
      chk("v4", 32'(v4), 32'(mode[1] == 2));
      chk("b4", 32'(b4), 32'(mode[1] == 1));
   endtask

   // inputs are changed at negedge, sampled at posedge, checked at negedge
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step(0, s16, p16, a16);
      model_step(1, s4, p4, a4);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic zeros_now(input string tag);
      chk({tag, "_el16"}, 32'(el16), 32'd0);
      chk({tag, "_v16"}, 32'(v16), 32'd0);
      chk({tag, "_b16"}, 32'(b16), 32'd0);
      chk({tag, "_ov16"}, 32'(ov16), 32'd0);
      chk({tag, "_el4"}, 32'(el4), 32'd0);
      chk({tag, "_b4"}, 32'(b4), 32'd0);
   endtask

   // runs a 4-bit measurement of n cycles and checks the capture
   task automatic run4(input int n, input logic [3:0] e_el,
                       input logic e_ov, input string tag);
      s4 = 1'b1; tick();
      s4 = 1'b0;
      idle(n - 1);
      p4 = 1'b1; tick();
      chk({tag, "_el"}, 32'(el4), 32'(e_el));
      chk({tag, "_ov"}, 32'(ov4), 32'(e_ov));
      chk({tag, "_v"}, 32'(v4), 32'd1);
      p4 = 1'b0; a4 = 1'b1; tick();
      a4 = 1'b0;
      chk({tag, "_ackv"}, 32'(v4), 32'd0);
   endtask

   initial begin
      maxv[0] = 65535;
      maxv[1] = 15;
      reset = 1'b1;
      model_reset();
      #1;
      zeros_now("rst");
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // 5-cycle measurement, stop held two cycles
      s16 = 1'b1; tick();
      s16 = 1'b0; idle(4);
      p16 = 1'b1; tick();
      chk("d5_el", 32'(el16), 32'd5);
      chk("d5_v", 32'(v16), 32'd1);
      chk("d5_b", 32'(b16), 32'd0);
      tick();
      p16 = 1'b0; idle(2);
      chk("d5_hold", 32'(el16), 32'd5);

      // new start/stop while holding: ignored
      s16 = 1'b1; tick();
      s16 = 1'b0; tick();
      p16 = 1'b1; tick();
      p16 = 1'b0; tick();
      chk("lost_el", 32'(el16), 32'd5);
      chk("lost_v", 32'(v16), 32'd1);

      // ack with start in same cycle re-arms
      a16 = 1'b1; s16 = 1'b1; tick();
      a16 = 1'b0; s16 = 1'b0;
      chk("ackst_b", 32'(b16), 32'd1);
      chk("ackst_v", 32'(v16), 32'd0);
      idle(2);
      p16 = 1'b1; tick();
      p16 = 1'b0;
      chk("ackst_el", 32'(el16), 32'd3);
      a16 = 1'b1; tick();
      a16 = 1'b0;
      chk("ack_v", 32'(v16), 32'd0);

      // restart mid-count: start 0, start 3, stop 7
      s16 = 1'b1; tick();
      s16 = 1'b0; idle(2);
      s16 = 1'b1; tick();
      s16 = 1'b0; idle(3);
      p16 = 1'b1; tick();
      p16 = 1'b0;
      chk("rst_el", 32'(el16), 32'd4);
      a16 = 1'b1; tick();
      a16 = 1'b0;

      // simultaneous start and stop in idle
      s16 = 1'b1; p16 = 1'b1; tick();
      s16 = 1'b0; p16 = 1'b0;
      chk("sim_b", 32'(b16), 32'd1);
      chk("sim_v", 32'(v16), 32'd0);
      idle(1);
      p16 = 1'b1; tick();
      p16 = 1'b0;
      chk("sim_el", 32'(el16), 32'd2);
      a16 = 1'b1; tick();
      a16 = 1'b0;

      // 4-bit saturation boundaries
      run4(14, 4'd14, 1'b0, "n14");
      run4(15, 4'd15, 1'b0, "n15");
      run4(16, 4'd15, 1'b1, "n16");
      run4(40, 4'd15, 1'b1, "n40");

      // reset in the middle of a count (cnt=7)
      s16 = 1'b1; tick();
      s16 = 1'b0; idle(6);
      chk("pre_b", 32'(b16), 32'd1);
      #2 reset = 1'b1;
      model_reset();
      #1;
      zeros_now("mid");
      @(negedge clk);
      s16 = 1'b1; p16 = 1'b1; s4 = 1'b1; p4 = 1'b1;
      reset = 1'b0;
      idle(3);
      chk("held_b", 32'(b16), 32'd0);
      chk("held_v", 32'(v16), 32'd0);
      s16 = 1'b0; p16 = 1'b0; s4 = 1'b0; p4 = 1'b0;
      idle(1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s16 = ($urandom_range(0, 7) == 0);
         p16 = ($urandom_range(0, 5) == 0);
         a16 = ($urandom_range(0, 3) == 0);
         s4  = ($urandom_range(0, 15) == 0);
         p4  = ($urandom_range(0, 19) == 0);
         a4  = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/interval_capture.md
INTERVAL_CAPTURE -- requirements
Module: interval_capture

Interface
REQ-001 Parameter: ISIZE, default 16, width of cycle counter and captured result (legal range 2..32).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  level signal; a rising edge arms a measurement.
REQ-005 stop  input  1  level signal (typically a timer callback output); a rising edge ends a measurement.
REQ-006 ack  input  1  consumer acknowledge; single-cycle high releases a captured result.
REQ-007 elapsed  output  ISIZE  captured interval in clk cycles, registered.
REQ-008 overflow  output  1  registered alongside elapsed; high = counter saturated before stop.
REQ-009 valid  output  1  high while a captured result awaits ack.
REQ-010 busy  output  1  high while a measurement is in progress.

Function
REQ-011 Edge detect: start_q and stop_q are registered copies of start and stop. start_edge = start & !start_q; stop_edge = stop & !stop_q.
REQ-012 A stop pulse held high for several cycles (e.g. 2) produces exactly one stop_edge.
REQ-013 States: IDLE, COUNT, DONE; the encoding is free. busy = (state==COUNT); valid = (state==DONE); both are decoded from registered state only.
REQ-014 IDLE: start_edge -> COUNT with cnt<=1. Any stop_edge -> ignored. A simultaneous start_edge and stop_edge -> COUNT; the stop is ignored.
REQ-015 COUNT, stop_edge with no start_edge -> DONE. elapsed<=cnt; overflow<=sat; cnt unchanged.
REQ-016 COUNT, start_edge (with or without stop_edge): restart. cnt<=1, sat<=0, stay COUNT. elapsed and overflow are unchanged.
REQ-017 COUNT, no edges: if cnt != all-ones then cnt<=cnt+1. Otherwise cnt holds at all-ones and sat<=1.
REQ-018 Resulting semantics: a start_edge sampled at edge T and a stop_edge sampled at edge T+N give elapsed=N for 1 <= N < 2^ISIZE-1, with overflow=0.
REQ-019 Saturation: for N >= 2^ISIZE-1, elapsed=2^ISIZE-1. overflow=1 only when N > 2^ISIZE-1.
REQ-020 DONE: elapsed and overflow hold stable. start_edge and stop_edge without ack -> ignored (edge lost, no queueing).
REQ-021 DONE, ack: without start_edge -> IDLE. With a simultaneous start_edge -> COUNT with cnt<=1, sat<=0.
REQ-022 ack in IDLE or COUNT -> no effect.
REQ-023 elapsed and overflow change only on the DONE transition of REQ-015. They retain their last value in IDLE and COUNT.
REQ-024 The counter arithmetic is ISIZE bits, unsigned, and never wraps.
REQ-025 Latency: valid rises the cycle after the stop_edge sample. valid falls the cycle after the ack sample.

Reset
REQ-026 While reset is high: state=IDLE; cnt=0; sat=0; elapsed=0; overflow=0; valid=0; busy=0.
REQ-027 While reset is high: start_q=1 and stop_q=1. A level already high at reset release is not an edge.
REQ-028 Reset asserted mid-COUNT or mid-DONE aborts the operation; the captured result is lost.
REQ-029 Following deassertion of reset, the first edge evaluation occurs on the first clk rising edge.

Verification
REQ-030 ISIZE=16. Start pulse (1 cycle) at edge 10, stop rises at edge 15 and is held 2 cycles -> valid at edge 16, elapsed=5, overflow=0, busy low from edge 16. ack at edge 20 -> valid=0 from edge 21.
REQ-031 ISIZE=4. Start at edge 0, stop at edge 15 -> elapsed=15, overflow=0. Repeat with stop at edge 16 -> elapsed=15, overflow=1. Repeat with stop at edge 40 -> elapsed=15, overflow=1.
REQ-032 Start at 0, second start at 3, stop at 7 -> elapsed=4. Simultaneous start+stop in IDLE -> busy=1, valid=0.
REQ-033 In DONE with elapsed=5, a new start/stop pair without ack -> elapsed stays 5. ack+start in the same cycle -> busy=1 next cycle; a stop 3 cycles later -> elapsed=3.
REQ-034 stop and start held high through reset release -> no edges, stays IDLE. Reset asserted mid-COUNT (cnt=7) -> all outputs 0 asynchronously, state=IDLE.
